sd_stream_uart_bridge: RTL and testbench
========================================

// Module: sd_stream_uart_bridge
// PURPOSE
//   Buffers the byte stream from the SD file reader (no backpressure) and feeds a ready/valid UART TX.
//   Output is raw bytes or an ASCII hex dump; UART RX commands reset the source, pause or resume.
//   Sits between sd_file_reader (outen/outbyte) and uart_tx (i_tvalid/i_tready/i_tdata).
// PARAMETERS
//   FIFO_AW     10     FIFO depth = 2**FIFO_AW bytes
//   MODE        "RAW"  "RAW": byte passthrough; "HEX": 2 uppercase hex chars + separator per byte
//   LINE_BYTES  16     HEX mode: bytes per line; separator is CR,LF after every LINE_BYTES-th byte, else space
//   RST_CYCLES  16     cycles o_src_rstn is held low after any reset (min 1)
//   CMD_RESET   "r"    command char: reset source and bridge
//   CMD_PAUSE   "p"    command char: pause output
//   CMD_RESUME  "c"    command char: resume output
// PORTS
//   clk          in   1   system clock
//   rstn         in   1   synchronous active-low reset
//   i_cmd_valid  in   1   command byte strobe (from uart_rx)
//   i_cmd_data   in   8   command byte
//   i_valid      in   1   source byte strobe (sd_file_reader outen)
//   i_data       in   8   source byte
//   o_src_rstn   out  1   reset to source (sd_file_reader rstn)
//   o_tvalid     out  1   output char valid
//   o_tready     in   1   sink ready
//   o_tdata      out  8   output char
//   o_paused     out  1   1 = paused
//   o_overflow   out  1   sticky: a source byte was dropped (FIFO full)
//   o_byte_cnt   out  32  source bytes accepted into FIFO since last reset (wraps)
//   o_checksum   out  8   running mod-256 sum of accepted bytes (see CONFIGURATION)
// BEHAVIOUR
//   Reset values: o_src_rstn=0, o_tvalid=0, o_tdata=0, o_paused=0, o_overflow=0, o_byte_cnt=0, o_checksum=0.
//   Soft reset (i_cmd_valid && i_cmd_data==CMD_RESET): same effect as rstn low: FIFO flushed, formatter IDLE,
//     counters/flags cleared, o_tvalid drops next cycle even if unaccepted.
//   o_src_rstn: low while rstn low, then low RST_CYCLES more cycles after rstn release or soft reset; re-trigger restarts count.
//   i_valid ignored while o_src_rstn=0 or in the soft-reset cycle (reset wins over same-cycle byte).
//   FIFO write: accepted if occupancy<DEPTH, or occupancy==DEPTH with a pop in same cycle; else byte dropped,
//     o_overflow=1 (sticky until reset), o_byte_cnt/o_checksum unchanged.
//   Handshake: o_tvalid, once high, holds o_tdata stable until o_tvalid&&o_tready; no combinational tready->tvalid path.
//   Formatter FSM: IDLE -> (FIFO non-empty && !o_paused: pop) -> RAW: BYTE -> IDLE
//                                                          HEX: HI -> LO -> SP -> IDLE, or HI -> LO -> CR -> LF -> IDLE.
//     Each non-IDLE state presents one char; advances on accept. Hex digits '0'-'9','A'-'F'.
//     Line position counter 0..LINE_BYTES-1 picks CR,LF at LINE_BYTES-1, then wraps to 0; cleared by reset.
//   Latency: FIFO empty, formatter IDLE, byte written at edge N -> o_tvalid=1 after edge N+2.
//   Back-to-back: with o_tready=1, one char per cycle (no IDLE bubble between groups when FIFO non-empty).
//   Pause: CMD_PAUSE sets o_paused next cycle; formatter finishes the current group (HEX) or pending char (RAW),
//     then stays IDLE. Input keeps filling FIFO. CMD_RESUME clears o_paused. Repeated commands idempotent.
//   Other command bytes ignored. Command and i_valid in same cycle (non-reset): both take effect.
// CONFIGURATION
//   SD_STREAM_BRIDGE_CHECKSUM_EN defined: o_checksum += i_data (mod 256) on every accepted write; cleared by reset.
//   Not defined: o_checksum tied to 8'h00, no adder logic.
// TESTING
//   RAW, tready=1: write 0x41,0x42,0x43 on consecutive cycles -> o_tdata 'A','B','C' on consecutive cycles,
//     first o_tvalid 2 edges after first write; o_byte_cnt=3.
//   HEX, LINE_BYTES=2: write 0x0F,0xA5,0x3C -> "0F A5\r\n3C " (0x30,0x46,0x20,0x41,0x35,0x0D,0x0A,0x33,0x43,0x20).
//   FIFO_AW=2, tready=0: write 6 bytes -> first 4 kept, o_overflow=1, o_byte_cnt=4; tready=1 -> exactly 4 bytes out.
//   tready toggling randomly -> o_tdata never changes while o_tvalid=1 && o_tready=0; stream order preserved.
//   HEX, 'p' mid-group (after 'H' char accepted) -> LO and SP still emitted, then o_tvalid=0; 'c' -> resumes next byte.
//   'r' with data queued and o_tvalid=1 -> o_tvalid=0 next cycle, o_src_rstn low exactly RST_CYCLES cycles,
//     counters 0; with CHECKSUM_EN, writes 0xFF,0x02 -> o_checksum=0x01.

Source files
------------

// File: rtl/sd_stream_uart_bridge.sv
// Byte FIFO between sd_file_reader and uart_tx, emitting raw bytes or a hex dump.
// Define SD_STREAM_BRIDGE_CHECKSUM_EN to build the running checksum on o_checksum.
module sd_stream_uart_bridge #(
    parameter int         FIFO_AW    = 10,
    parameter             MODE       = "RAW",
    parameter int         LINE_BYTES = 16,
    parameter int         RST_CYCLES = 16,
    parameter logic [7:0] CMD_RESET  = "r",
    parameter logic [7:0] CMD_PAUSE  = "p",
    parameter logic [7:0] CMD_RESUME = "c"
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_cmd_valid,
    input  logic [7:0]  i_cmd_data,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_src_rstn,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [7:0]  o_tdata,
    output logic        o_paused,
    output logic        o_overflow,
    output logic [31:0] o_byte_cnt,
    output logic [7:0]  o_checksum
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam bit IS_HEX = (MODE == "HEX");
    localparam int LW     = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int RW     = $clog2(RST_CYCLES + 1);
    localparam int CW     = FIFO_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE,
        S_HI,
        S_LO,
        S_SP,
        S_CR,
        S_LF
    } state_t;

    localparam state_t FIRST = IS_HEX ? S_HI : S_BYTE;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               avail_q, avail_d;
    logic               paused_q, paused_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [LW-1:0]      line_q, line_d;
    logic [RW-1:0]      rst_cnt_q, rst_cnt_d;

    logic       soft_rst;
    logic       clr;
    logic       src_ok;
    logic       wr_en;
    logic       wr_ok;
    logic       tvalid;
    logic       accept;
    logic       pop;
    logic       more;
    logic [7:0] head;
    logic [7:0] tdata;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign soft_rst = i_cmd_valid && (i_cmd_data == CMD_RESET);
    assign clr      = !rstn || soft_rst;
    assign src_ok   = (rst_cnt_q == '0);
    assign wr_en    = i_valid && src_ok && !clr;
    assign head     = mem_q[rptr_q];
    assign tvalid   = (state_q != S_IDLE);
    assign accept   = tvalid && o_tready;
    // head is the byte being formatted; a second queued byte lets groups chain
    assign more     = (count_q > CW'(1));

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (avail_q && !paused_q) state_d = FIRST;
            end
            S_BYTE, S_SP, S_LF: begin
                if (accept) begin
                    pop     = 1'b1;
                    state_d = (more && !paused_q) ? FIRST : S_IDLE;
                end
            end
            S_HI: begin
                if (accept) state_d = S_LO;
            end
            S_LO: begin
                if (accept) begin
                    if (line_q == LW'(LINE_BYTES - 1)) begin
                        state_d = S_CR;
                        line_d  = '0;
                    end else begin
                        state_d = S_SP;
                        line_d  = line_q + 1'b1;
                    end
                end
            end
            S_CR: begin
                if (accept) state_d = S_LF;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tdata = 8'h00;
        unique case (state_q)
            S_BYTE:  tdata = head;
            S_HI:    tdata = hex_char(head[7:4]);
            S_LO:    tdata = hex_char(head[3:0]);
            S_SP:    tdata = 8'h20;
            S_CR:    tdata = 8'h0D;
            S_LF:    tdata = 8'h0A;
            default: tdata = 8'h00;
        endcase
    end

    always_comb begin
        wr_ok     = wr_en && ((count_q != CW'(DEPTH)) || pop);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q | (wr_en & ~wr_ok);
        paused_d  = paused_q;
        rst_cnt_d = rst_cnt_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 32'd1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        if (wr_ok && !pop) count_d = count_q + 1'b1;
        if (!wr_ok && pop) count_d = count_q - 1'b1;
        // formatter sees a new byte one cycle after it lands
        avail_d = pop ? more : (count_q != '0);
        if (i_cmd_valid && (i_cmd_data == CMD_PAUSE)) paused_d = 1'b1;
        else if (i_cmd_valid && (i_cmd_data == CMD_RESUME)) paused_d = 1'b0;
        if (!src_ok) rst_cnt_d = rst_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            avail_q   <= 1'b0;
            paused_q  <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            line_q    <= '0;
            rst_cnt_q <= RW'(RST_CYCLES);
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            avail_q   <= avail_d;
            paused_q  <= paused_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

`ifdef SD_STREAM_BRIDGE_CHECKSUM_EN
    logic [7:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (wr_ok) cks_d = cks_q + i_data;
    end

    always_ff @(posedge clk) begin
        if (clr) cks_q <= '0;
        else     cks_q <= cks_d;
    end

    assign o_checksum = cks_q;
`else
    assign o_checksum = 8'h00;
`endif

    assign o_src_rstn = src_ok;
    assign o_tvalid   = tvalid;
    assign o_tdata    = tdata;
    assign o_paused   = paused_q;
    assign o_overflow = ovf_q;
    assign o_byte_cnt = cnt_q;

endmodule

// File: tb/tb_sd_stream_uart_bridge.sv
// Bench for sd_stream_uart_bridge: a RAW instance (depth 4) and a HEX instance
// (depth 16, 2 bytes per line) share stimulus and are checked against a char-queue model.
`timescale 1ns/1ps
module tb_sd_stream_uart_bridge;

    localparam int RST = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tready = 1'b0;

    logic        src [2];
    logic        tv  [2];
    logic [7:0]  td  [2];
    logic        pz  [2];
    logic        ov  [2];
    logic [31:0] bc  [2];
    logic [7:0]  ck  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_stream_uart_bridge #(
        .FIFO_AW(2), .MODE("RAW"), .LINE_BYTES(16), .RST_CYCLES(RST)
    ) u_raw (
        .clk(clk), .rstn(rstn), .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data),
        .i_valid(valid), .i_data(data), .o_src_rstn(src[0]), .o_tvalid(tv[0]),
        .o_tready(tready), .o_tdata(td[0]), .o_paused(pz[0]), .o_overflow(ov[0]),
        .o_byte_cnt(bc[0]), .o_checksum(ck[0])
    );

    sd_stream_uart_bridge #(
        .FIFO_AW(4), .MODE("HEX"), .LINE_BYTES(2), .RST_CYCLES(RST)
    ) u_hex (
        .clk(clk), .rstn(rstn), .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data),
        .i_valid(valid), .i_data(data), .o_src_rstn(src[1]), .o_tvalid(tv[1]),
        .o_tready(tready), .o_tdata(td[1]), .o_paused(pz[1]), .o_overflow(ov[1]),
        .o_byte_cnt(bc[1]), .o_checksum(ck[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected chars per instance, bit 8 marks the last char of a byte's group
    logic [8:0] eq [2][$];
    logic [7:0] cap [2][$];
    bit         cap_en = 1'b0;
    int         occ [2];
    int         line_pos [2];
    int         src_cnt [2];
    bit         m_pz [2];
    bit         m_ov [2];
    logic [31:0] m_bc [2];
    logic [7:0]  m_ck [2];
    bit         hold [2];
    bit         bnd [2];
    bit         bpz [2];
    bit         prev_clr = 1'b0;
    bit         m_on = 1'b0;
    string      hexs = "0123456789ABCDEF";

    function automatic int depth(input int d);
        return (d == 0) ? 4 : 16;
    endfunction

    task automatic enq(input int d, input logic [7:0] b);
        if (d == 0) begin
            eq[0].push_back({1'b1, b});
        end else begin
            eq[1].push_back({1'b0, hexs[b[7:4]]});
            eq[1].push_back({1'b0, hexs[b[3:0]]});
            if (line_pos[1] == 1) begin
                eq[1].push_back({1'b0, 8'h0D});
                eq[1].push_back({1'b1, 8'h0A});
                line_pos[1] = 0;
            end else begin
                eq[1].push_back({1'b1, 8'h20});
                line_pos[1]++;
            end
        end
    endtask

    always @(negedge clk) begin
        bit clr;
        bit acc [2];
        bit last [2];
        clr = !rstn || (cmd_valid && cmd_data == "r");
        for (int d = 0; d < 2; d++) begin
            acc[d]  = tv[d] && tready;
            last[d] = 1'b0;
            if (m_on) begin
                chk("src_rstn", src[d], src_cnt[d] == 0);
                chk("paused", pz[d], m_pz[d]);
                chk("overflow", ov[d], m_ov[d]);
                chk("byte_cnt", bc[d], m_bc[d]);
`ifdef SD_STREAM_BRIDGE_CHECKSUM_EN
                chk("checksum", ck[d], m_ck[d]);
`else
                chk("checksum", ck[d], 8'h00);
`endif
                if (hold[d]) chk("tvalid_held", tv[d], 1);
                if (bnd[d] && bpz[d] && !prev_clr) chk("start_while_paused", tv[d], 0);
                if (tv[d]) begin
                    if (eq[d].size() == 0) begin
                        chk("spurious_tvalid", tv[d], 0);
                    end else begin
                        chk("tdata", td[d], eq[d][0][7:0]);
                        if (acc[d]) begin
                            last[d] = eq[d][0][8];
                            void'(eq[d].pop_front());
                        end
                    end
                end
                hold[d] = tv[d] && !tready && !clr;
                bnd[d]  = !tv[d] || (acc[d] && last[d]);
                bpz[d]  = m_pz[d];
            end
            if (clr) begin
                eq[d].delete();
                occ[d] = 0;
                line_pos[d] = 0;
                src_cnt[d] = RST;
                m_pz[d] = 1'b0;
                m_ov[d] = 1'b0;
                m_bc[d] = '0;
                m_ck[d] = '0;
            end else begin
                if (valid && src_cnt[d] == 0) begin
                    if (occ[d] < depth(d) || last[d]) begin
                        enq(d, data);
                        occ[d]++;
                        m_bc[d] = m_bc[d] + 1;
                        m_ck[d] = m_ck[d] + data;
                    end else begin
                        m_ov[d] = 1'b1;
                    end
                end
                if (last[d]) occ[d]--;
                if (cmd_valid && cmd_data == "p") m_pz[d] = 1'b1;
                else if (cmd_valid && cmd_data == "c") m_pz[d] = 1'b0;
                if (src_cnt[d] > 0) src_cnt[d]--;
            end
        end
        prev_clr = clr;
        m_on = 1'b1;
    end

    always @(negedge clk) begin
        if (cap_en) begin
            for (int d = 0; d < 2; d++)
                if (tv[d] && tready) cap[d].push_back(td[d]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd_data = c;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_src();
        int n = 0;
        while (!(src[0] && src[1]) && n < 100) begin
            cyc();
            n++;
        end
        chk("src_release", src[0] && src[1], 1);
    endtask

    task automatic drain();
        int n = 0;
        valid = 1'b0;
        cmd_valid = 1'b0;
        tready = 1'b1;
        while ((eq[0].size() != 0 || eq[1].size() != 0) && n < 3000) begin
            cyc();
            n++;
        end
        chk("drain_raw_left", eq[0].size(), 0);
        chk("drain_hex_left", eq[1].size(), 0);
        cyc();
        cyc();
        chk("idle_raw_tvalid", tv[0], 0);
        chk("idle_hex_tvalid", tv[1], 0);
    endtask

    initial begin
        logic [7:0] hex_exp [10];
        logic [7:0] p_exp [6];
        logic [7:0] oth [4];
        int n;
        int r;
        hex_exp = '{8'h30, 8'h46, 8'h20, 8'h41, 8'h35, 8'h0D, 8'h0A, 8'h33, 8'h43, 8'h20};
        p_exp = '{8'h41, 8'h20, 8'h36, 8'h42, 8'h0D, 8'h0A};
        oth = '{8'h61, 8'h78, 8'h30, 8'h00};

        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            chk("rst_src_rstn", src[d], 0);
            chk("rst_tvalid", tv[d], 0);
            chk("rst_tdata", td[d], 0);
            chk("rst_paused", pz[d], 0);
            chk("rst_overflow", ov[d], 0);
            chk("rst_byte_cnt", bc[d], 0);
            chk("rst_checksum", ck[d], 0);
        end
        rstn = 1'b1;
        wait_src();

        tready = 1'b1;
        valid = 1'b1;
        data = 8'h41;
        cyc();
        chk("raw_lat_n", tv[0], 0);
        data = 8'h42;
        cyc();
        chk("raw_lat_n1", tv[0], 0);
        data = 8'h43;
        cyc();
        chk("raw_lat_n2", tv[0], 1);
        chk("raw_A", td[0], 8'h41);
        valid = 1'b0;
        cyc();
        chk("raw_B_valid", tv[0], 1);
        chk("raw_B", td[0], 8'h42);
        cyc();
        chk("raw_C_valid", tv[0], 1);
        chk("raw_C", td[0], 8'h43);
        chk("raw_cnt3", bc[0], 3);
        drain();

        cmd("r");
        wait_src();
        cap[0].delete();
        cap[1].delete();
        cap_en = 1'b1;
        valid = 1'b1;
        data = 8'h0F;
        cyc();
        data = 8'hA5;
        cyc();
        data = 8'h3C;
        cyc();
        drain();
        cap_en = 1'b0;
        chk("hex_len", cap[1].size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < cap[1].size()) chk("hex_char", cap[1][i], hex_exp[i]);
        chk("raw_len", cap[0].size(), 3);
        if (cap[0].size() == 3) begin
            chk("raw_0F", cap[0][0], 8'h0F);
            chk("raw_A5", cap[0][1], 8'hA5);
            chk("raw_3C", cap[0][2], 8'h3C);
        end

        cmd("r");
        wait_src();
        tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            valid = 1'b1;
            data = 8'(i);
            cyc();
        end
        valid = 1'b0;
        cyc();
        chk("ovf_raw", ov[0], 1);
        chk("ovf_raw_cnt", bc[0], 4);
        chk("ovf_hex", ov[1], 0);
        chk("ovf_hex_cnt", bc[1], 6);
        cap[0].delete();
        cap_en = 1'b1;
        drain();
        cap_en = 1'b0;
        chk("ovf_out_len", cap[0].size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < cap[0].size()) chk("ovf_out", cap[0][i], 8'(i + 1));

        cmd("r");
        wait_src();
        tready = 1'b0;
        valid = 1'b1;
        data = 8'h5A;
        cyc();
        data = 8'h6B;
        cyc();
        valid = 1'b0;
        n = 0;
        while (!tv[1] && n < 20) begin
            cyc();
            n++;
        end
        chk("pause_hi_valid", tv[1], 1);
        chk("pause_hi", td[1], 8'h35);
        tready = 1'b1;
        cyc();
        tready = 1'b0;
        cmd("p");
        chk("pause_flag", pz[1], 1);
        cap[1].delete();
        cap_en = 1'b1;
        tready = 1'b1;
        repeat (12) cyc();
        chk("pause_stopped", tv[1], 0);
        chk("pause_len", cap[1].size(), 2);
        cmd("c");
        drain();
        cap_en = 1'b0;
        chk("resume_len", cap[1].size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < cap[1].size()) chk("resume_char", cap[1][i], p_exp[i]);

        tready = 1'b0;
        valid = 1'b1;
        data = 8'h11;
        cyc();
        data = 8'h22;
        cyc();
        data = 8'h33;
        cyc();
        valid = 1'b0;
        n = 0;
        while (!(tv[0] && tv[1]) && n < 20) begin
            cyc();
            n++;
        end
        chk("sr_pre_valid", tv[0] && tv[1], 1);
        cmd("r");
        chk("sr_raw_tvalid", tv[0], 0);
        chk("sr_hex_tvalid", tv[1], 0);
        chk("sr_raw_cnt", bc[0], 0);
        chk("sr_hex_cnt", bc[1], 0);
        n = 0;
        while (!src[0] && n < 100) begin
            n++;
            cyc();
        end
        chk("sr_src_low_cycles", n, RST);
        valid = 1'b1;
        data = 8'hFF;
        cyc();
        data = 8'h02;
        cyc();
        valid = 1'b0;
        cyc();
`ifdef SD_STREAM_BRIDGE_CHECKSUM_EN
        chk("cks_ff02", ck[0], 8'h01);
`else
        chk("cks_off", ck[0], 8'h00);
`endif
        drain();

        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            tready = ((i % 250) < 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
            valid = $urandom_range(0, 1);
            data = 8'($urandom);
            cmd_valid = 1'b0;
            if (r < 15) begin
                cmd_valid = 1'b1;
                cmd_data = "p";
            end else if (r < 30) begin
                cmd_valid = 1'b1;
                cmd_data = "c";
            end else if (r < 33) begin
                cmd_valid = 1'b1;
                cmd_data = "r";
            end else if (r < 45) begin
                cmd_valid = 1'b1;
                cmd_data = oth[r % 4];
            end
            cyc();
        end
        valid = 1'b0;
        cmd("c");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
